// File: rtl/score_pkg.sv
// Shared constants for the score digit raster: cell geometry, the per-line
// scan state and the 8x8 digit font (bit 7 is the leftmost pixel of a row).
package score_pkg;

    localparam int CELL_W = 8;
    localparam int CELL_H = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    localparam logic [7:0] FONT [10][8] = '{
        '{8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h18, 8'h38, 8'h18, 8'h18, 8'h18, 8'h18, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00},
        '{8'h3C, 8'h66, 8'h06, 8'h1C, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h0C, 8'h1C, 8'h3C, 8'h6C, 8'h7E, 8'h0C, 8'h0C, 8'h00},
        '{8'h7E, 8'h60, 8'h7C, 8'h06, 8'h06, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h60, 8'h7C, 8'h66, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h7E, 8'h06, 8'h0C, 8'h18, 8'h30, 8'h30, 8'h30, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3C, 8'h66, 8'h66, 8'h3C, 8'h00},
        '{8'h3C, 8'h66, 8'h66, 8'h3E, 8'h06, 8'h0C, 8'h38, 8'h00}
    };

endpackage

// File: rtl/score_digit_scan_if.sv
// Video-side signal bundle between the timing/score source and the digit scanner.
interface score_digit_scan_if;
    logic       ce_pix;
    logic       hsync;
    logic       vsync;
    logic [7:0] score1;
    logic [7:0] score2;
    logic [2:0] sel;
    logic [7:0] data;
    logic       strobe_n;

    modport master (
        output ce_pix, hsync, vsync, score1, score2,
        input  sel, data, strobe_n
    );

    modport slave (
        input  ce_pix, hsync, vsync, score1, score2,
        output sel, data, strobe_n
    );
endinterface

// File: rtl/score_glyph_rom.sv
// Combinational digit glyph lookup; non-BCD nibbles and forced blanks read as an empty row.
module score_glyph_rom
    import score_pkg::*;
(
    input  logic [3:0] digit,
    input  logic [2:0] row,
    input  logic       force_blank,
    output logic [7:0] row_bits,
    output logic       blank
);

    // Blank detection and font row fetch
    always_comb begin
        blank    = force_blank || (digit > 4'd9);
        row_bits = 8'h00;
        if (blank) begin
            row_bits = 8'h00;
        end else begin
            row_bits = FONT[digit][row];
        end
    end

endmodule

// File: rtl/score_digit_scan.sv
// Score digit raster scanner: tracks beam position from sync pulses, latches the
// scores once per frame and feeds column select, glyph row and strobe to the 1-of-8 selector.
module score_digit_scan
    import score_pkg::*;
#(
    parameter int H_LEFT   = 64,
    parameter int H_RIGHT  = 192,
    parameter int V_TOP    = 16,
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    score_digit_scan_if.slave  bus
);

    localparam logic [9:0] HL_LO = 10'(H_LEFT);
    localparam logic [9:0] HL_HI = 10'(H_LEFT + 2 * CELL_W);
    localparam logic [9:0] HR_LO = 10'(H_RIGHT);
    localparam logic [9:0] HR_HI = 10'(H_RIGHT + 2 * CELL_W);
    localparam logic [9:0] VT_LO = 10'(V_TOP);
    localparam logic [9:0] VT_HI = 10'(V_TOP + CELL_H);

    logic [8:0] hcnt_r, vcnt_r;
    logic [7:0] score1_r, score2_r;
    state_t     state_r, state_nxt_s;
    logic [2:0] sel_r;
    logic [7:0] data_r;
    logic       strobe_n_r;

    logic       hl_in_s, hr_in_s, row_ok_s, cell_valid_s, cell_start_s;
    logic [3:0] off_s;
    logic [2:0] row_s;
    logic [7:0] score_s;
    logic [3:0] digit_s;
    logic       lz_blank_s, blank_s, visible_s;
    logic [7:0] glyph_s;

    // Window decode; the left window takes precedence if the two overlap
    always_comb begin
        hl_in_s  = ({1'b0, hcnt_r} >= HL_LO) && ({1'b0, hcnt_r} < HL_HI);
        hr_in_s  = ({1'b0, hcnt_r} >= HR_LO) && ({1'b0, hcnt_r} < HR_HI);
        row_ok_s = ({1'b0, vcnt_r} >= VT_LO) && ({1'b0, vcnt_r} < VT_HI);
        row_s    = 3'(vcnt_r - 9'(V_TOP));
        if (hl_in_s) begin
            off_s   = 4'(hcnt_r - 9'(H_LEFT));
            score_s = score1_r;
        end else begin
            off_s   = 4'(hcnt_r - 9'(H_RIGHT));
            score_s = score2_r;
        end
        cell_valid_s = row_ok_s && (hl_in_s || hr_in_s);
        cell_start_s = row_ok_s && ((hcnt_r == 9'(H_LEFT)) || (hcnt_r == 9'(H_RIGHT)));
        digit_s      = off_s[3] ? score_s[3:0] : score_s[7:4];
        lz_blank_s   = BLANK_LZ && !off_s[3] && (digit_s == 4'd0);
    end

    score_glyph_rom u_rom (
        .digit       (digit_s),
        .row         (row_s),
        .force_blank (lz_blank_s),
        .row_bits    (glyph_s),
        .blank       (blank_s)
    );

    // Per-line scan state: a cell opens at its first column and closes when the window ends or a line starts
    always_comb begin
        state_nxt_s = IDLE;
        case (state_r)
            IDLE: begin
                if (!bus.hsync && cell_start_s) begin
                    state_nxt_s = ACTIVE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACTIVE: begin
                if (bus.hsync || !cell_valid_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
        visible_s = (state_nxt_s == ACTIVE) && !blank_s;
    end

    // Beam position counters and once-per-frame score shadow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_r   <= 9'd0;
            vcnt_r   <= 9'd0;
            score1_r <= 8'h00;
            score2_r <= 8'h00;
            state_r  <= IDLE;
        end else if (bus.ce_pix) begin
            if (bus.hsync) begin
                hcnt_r <= 9'd0;
            end else if (hcnt_r != 9'd511) begin
                hcnt_r <= hcnt_r + 9'd1;
            end else begin
                hcnt_r <= hcnt_r;
            end
            if (bus.vsync) begin
                vcnt_r   <= 9'd0;
                score1_r <= bus.score1;
                score2_r <= bus.score2;
            end else if (bus.hsync && (vcnt_r != 9'd511)) begin
                vcnt_r <= vcnt_r + 9'd1;
            end else begin
                vcnt_r <= vcnt_r;
            end
            state_r <= state_nxt_s;
        end else begin
            state_r <= state_r;
        end
    end

    // Selector drive registers; all three move together on the same enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_r      <= 3'd0;
            data_r     <= 8'h00;
            strobe_n_r <= 1'b1;
        end else if (bus.ce_pix) begin
            sel_r      <= visible_s ? off_s[2:0] : 3'd0;
            data_r     <= visible_s ? glyph_s : 8'h00;
            strobe_n_r <= !visible_s;
        end else begin
            sel_r      <= sel_r;
            data_r     <= data_r;
            strobe_n_r <= strobe_n_r;
        end
    end

    assign bus.sel      = sel_r;
    assign bus.data     = data_r;
    assign bus.strobe_n = strobe_n_r;

endmodule

// File: tb/tb_score_digit_scan.sv
// Directed bench for score_digit_scan: vector table of single-pixel probes plus
// hand-written sweeps for latency, frame latching, hsync abort, freeze and reset.
module tb_score_digit_scan;

    logic clk;
    logic reset;
    int   n_pass;
    int   n_total;
    int   h_cnt;

    score_digit_scan_if bus ();

    score_digit_scan #(
        .H_LEFT   (64),
        .H_RIGHT  (192),
        .V_TOP    (16),
        .BLANK_LZ (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] s1;
        logic [7:0] s2;
        int         line;
        int         h;
        logic [2:0] sel;
        logic [7:0] data;
        logic       sn;
    } vec_t;

    vec_t vecs [16];

    logic [7:0] d1_rows [5];
    logic [7:0] d2_rows [5];

    task automatic check(input string name, input logic [2:0] sel, input logic [7:0] data, input logic sn);
        n_total++;
        if (bus.sel === sel && bus.data === data && bus.strobe_n === sn) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got sel=%0d data=%h strobe_n=%b, want sel=%0d data=%h strobe_n=%b",
                     name, bus.sel, bus.data, bus.strobe_n, sel, data, sn);
        end
    endtask

    task automatic tick(input logic hs, input logic vs);
        bus.ce_pix = 1'b1;
        bus.hsync  = hs;
        bus.vsync  = vs;
        @(posedge clk);
        #1;
        bus.ce_pix = 1'b0;
        bus.hsync  = 1'b0;
        bus.vsync  = 1'b0;
        if (hs) h_cnt = 0;
        else if (h_cnt < 511) h_cnt = h_cnt + 1;
    endtask

    task automatic run_to(input int n);
        while (h_cnt < n) tick(1'b0, 1'b0);
    endtask

    task automatic goto_line(input int line);
        tick(1'b1, 1'b1);
        repeat (line) tick(1'b1, 1'b0);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        h_cnt   = 0;
        reset   = 1'b1;
        bus.ce_pix = 1'b0;
        bus.hsync  = 1'b0;
        bus.vsync  = 1'b0;
        bus.score1 = 8'h00;
        bus.score2 = 8'h00;

        vecs[0]  = '{8'h10, 8'h00, 16,  64, 3'd0, 8'h18, 1'b0};
        vecs[1]  = '{8'h10, 8'h00, 16,  67, 3'd3, 8'h18, 1'b0};
        vecs[2]  = '{8'h10, 8'h00, 16,  72, 3'd0, 8'h3C, 1'b0};
        vecs[3]  = '{8'h10, 8'h00, 16,  79, 3'd7, 8'h3C, 1'b0};
        vecs[4]  = '{8'h10, 8'h00, 16,  80, 3'd0, 8'h00, 1'b1};
        vecs[5]  = '{8'h10, 8'h00, 16,  63, 3'd0, 8'h00, 1'b1};
        vecs[6]  = '{8'h00, 8'h07, 16, 192, 3'd0, 8'h00, 1'b1};
        vecs[7]  = '{8'h00, 8'h07, 17, 200, 3'd0, 8'h06, 1'b0};
        vecs[8]  = '{8'h00, 8'h07, 16, 207, 3'd7, 8'h7E, 1'b0};
        vecs[9]  = '{8'h0A, 8'h00, 16,  72, 3'd0, 8'h00, 1'b1};
        vecs[10] = '{8'h0A, 8'h00, 16,  64, 3'd0, 8'h00, 1'b1};
        vecs[11] = '{8'h10, 8'h00, 15,  64, 3'd0, 8'h00, 1'b1};
        vecs[12] = '{8'h10, 8'h00, 24,  64, 3'd0, 8'h00, 1'b1};
        vecs[13] = '{8'h99, 8'h00, 23,  64, 3'd0, 8'h00, 1'b0};
        vecs[14] = '{8'h98, 8'h00, 18,  75, 3'd3, 8'h66, 1'b0};
        vecs[15] = '{8'h00, 8'h45, 19, 195, 3'd3, 8'h6C, 1'b0};

        d1_rows = '{8'h18, 8'h18, 8'h18, 8'h7E, 8'h00};
        d2_rows = '{8'h3C, 8'h0C, 8'h30, 8'h60, 8'h7E};
        d2_rows = '{8'h0C, 8'h30, 8'h60, 8'h7E, 8'h00};

        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 3'd0, 8'h00, 1'b1);
        @(negedge clk);
        reset = 1'b0;

        // Single-pixel probes: output for hcnt=h is visible once hcnt reaches h+1
        for (int i = 0; i < 16; i++) begin
            bus.score1 = vecs[i].s1;
            bus.score2 = vecs[i].s2;
            goto_line(vecs[i].line);
            run_to(vecs[i].h + 1);
            check($sformatf("vec%0d", i), vecs[i].sel, vecs[i].data, vecs[i].sn);
        end

        // Full sweep across player-1 cells, row 0 of "10"
        bus.score1 = 8'h10;
        goto_line(16);
        run_to(64);
        for (int i = 0; i < 16; i++) begin
            tick(1'b0, 1'b0);
            check($sformatf("sweep%0d", i), 3'(i % 8), (i < 8) ? 8'h18 : 8'h3C, 1'b0);
        end
        tick(1'b0, 1'b0);
        check("sweep_end", 3'd0, 8'h00, 1'b1);

        // Score change mid-frame must wait for the next vsync
        bus.score1 = 8'h12;
        goto_line(19);
        bus.score1 = 8'h34;
        for (int r = 0; r < 5; r++) begin
            run_to(65);
            check($sformatf("mid_tens_r%0d", r + 3), 3'd0, d1_rows[r], 1'b0);
            run_to(73);
            check($sformatf("mid_units_r%0d", r + 3), 3'd0, d2_rows[r], 1'b0);
            tick(1'b1, 1'b0);
        end
        goto_line(16);
        run_to(65);
        check("next_frame_tens", 3'd0, 8'h3C, 1'b0);
        run_to(73);
        check("next_frame_units", 3'd0, 8'h0C, 1'b0);

        // hsync inside a cell, then a frozen ce_pix
        bus.score1 = 8'h10;
        goto_line(16);
        run_to(69);
        check("pre_hsync", 3'd4, 8'h18, 1'b0);
        tick(1'b1, 1'b0);
        check("hsync_abort", 3'd0, 8'h00, 1'b1);
        run_to(65);
        check("hsync_restart", 3'd0, 8'h38, 1'b0);
        run_to(68);
        check("pre_freeze", 3'd3, 8'h38, 1'b0);
        bus.hsync = 1'b1;
        bus.vsync = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("freeze%0d", i), 3'd3, 8'h38, 1'b0);
        end
        bus.hsync = 1'b0;
        bus.vsync = 1'b0;
        tick(1'b0, 1'b0);
        check("post_freeze", 3'd4, 8'h38, 1'b0);

        // Asynchronous reset in the middle of a visible cell
        goto_line(16);
        run_to(67);
        check("pre_reset", 3'd2, 8'h18, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset", 3'd0, 8'h00, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        h_cnt = 0;
        run_to(65);
        check("post_reset_h64", 3'd0, 8'h00, 1'b1);
        run_to(73);
        check("post_reset_h72", 3'd0, 8'h00, 1'b1);
        goto_line(16);
        run_to(65);
        check("post_reset_frame", 3'd0, 8'h18, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
